// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-command decoder driving N_CH latched channels with holdoff and ACK/NAK replies.
// Optional watchdog that forces all channels OFF is built when CMD_WDT_EN is defined.
module uart_cmd_ctrl #(
    parameter int N_CH           = 4,
    parameter int HOLDOFF        = 12000000,
    parameter int OUT_ACTIVE_LOW = 1,
    parameter int WDT_CYCLES     = 24000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      rx_data,
    input  logic            rx_done,
    input  logic            parity_error,
    input  logic            tx_busy,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    output logic [N_CH-1:0] ch_out,
    output logic [15:0]     cmd_count,
    output logic [7:0]      err_count,
    output logic            wdt_trip
);

    localparam int HO_W = $clog2(HOLDOFF + 1);
    localparam logic [HO_W-1:0] HO_MAX = HO_W'(HOLDOFF);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXEC      = 3'd2;
    localparam logic [2:0] S_REPLY     = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;

    localparam logic [2:0] OP_ON     = 3'b101;
    localparam logic [2:0] OP_OFF    = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b110;
    localparam logic [2:0] OP_QUERY  = 3'b111;

    logic [2:0]      state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            perr_q, perr_d;
    logic [N_CH-1:0] ch_q, ch_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic [1:0]      wait_q, wait_d;
    logic [HO_W-1:0] ho_q, ho_d;
    logic [15:0]     cmd_cnt_q, cmd_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [2:0]      op;
    logic [4:0]      ch_idx;
    logic            op_on, op_ctrl, op_valid, ch_bad, ch_bit;
    logic [N_CH-1:0] ch_mask;
    logic            nak, ack, overrun, wdt_fire;
    logic [8:0]      err_sum;

    assign op       = cmd_q[7:5];
    assign ch_idx   = cmd_q[4:0];
    assign op_on    = (op == OP_ON) || (op == OP_TOGGLE);
    assign op_ctrl  = (op == OP_ON) || (op == OP_OFF) || (op == OP_TOGGLE);
    assign op_valid = op_ctrl || (op == OP_QUERY);
    assign ch_bad   = 32'(ch_idx) >= 32'(N_CH);
    assign ch_mask  = N_CH'(1) << ch_idx;
    assign ch_bit   = |(ch_q & ch_mask);
    assign overrun  = rx_done && (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        perr_d     = perr_q;
        ch_d       = ch_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        wait_d     = wait_q;
        ho_d       = (ho_q == HO_MAX) ? ho_q : ho_q + 1'b1;
        nak        = 1'b0;
        ack        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_done) begin
                    cmd_d   = rx_data;
                    perr_d  = parity_error;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                nak     = 1'b1;
                state_d = S_REPLY;
                if (perr_q)                            tx_data_d = 8'h61;
                else if (!op_valid)                    tx_data_d = 8'h62;
                else if (ch_bad)                       tx_data_d = 8'h63;
                else if (op_ctrl && (ho_q != HO_MAX))  tx_data_d = 8'h64;
                else begin
                    nak     = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ack     = 1'b1;
                state_d = S_REPLY;
                case (op)
                    OP_ON:     ch_d = ch_q | ch_mask;
                    OP_OFF:    ch_d = ch_q & ~ch_mask;
                    OP_TOGGLE: ch_d = ch_q ^ ch_mask;
                    default:   ch_d = ch_q;
                endcase
                tx_data_d = (op == OP_QUERY) ? {3'b001, 4'b0000, ch_bit} : {3'b100, ch_idx};
                if (op_ctrl) ho_d = '0;
            end
            S_REPLY: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    wait_d     = 2'd0;
                    state_d    = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // A transmitter that never raises busy must not wedge the controller.
                if (tx_busy)              state_d = S_WAIT_DONE;
                else if (wait_q == 2'd3)  state_d = S_IDLE;
                else                      wait_d  = wait_q + 2'd1;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (wdt_fire) ch_d = '0;
    end

    // A NAK and an overrun can land in the same cycle, so the error counter may step by two.
    assign err_sum   = {1'b0, err_cnt_q} + 9'(nak) + 9'(overrun);
    assign err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    assign cmd_cnt_d = (ack && (cmd_cnt_q != 16'hFFFF)) ? cmd_cnt_q + 16'd1 : cmd_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= 8'h00;
            perr_q     <= 1'b0;
            ch_q       <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            wait_q     <= 2'd0;
            ho_q       <= HO_MAX;
            cmd_cnt_q  <= 16'h0000;
            err_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            perr_q     <= perr_d;
            ch_q       <= ch_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            wait_q     <= wait_d;
            ho_q       <= ho_d;
            cmd_cnt_q  <= cmd_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

`ifdef CMD_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_trip_q, wdt_trip_d;

    always_comb begin
        wdt_cnt_d  = wdt_cnt_q;
        wdt_trip_d = wdt_trip_q;
        wdt_fire   = 1'b0;
        if (ack) begin
            wdt_cnt_d = '0;
            if (op_on) wdt_trip_d = 1'b0;
        end else if (wdt_cnt_q != WDT_W'(WDT_CYCLES)) begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
            if (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) begin
                wdt_fire   = 1'b1;
                wdt_trip_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt_q  <= '0;
            wdt_trip_q <= 1'b0;
        end else begin
            wdt_cnt_q  <= wdt_cnt_d;
            wdt_trip_q <= wdt_trip_d;
        end
    end

    assign wdt_trip = wdt_trip_q;
`else
    assign wdt_fire = 1'b0;
    assign wdt_trip = 1'b0;
`endif

    assign ch_out    = (OUT_ACTIVE_LOW != 0) ? ~ch_q : ch_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign cmd_count = cmd_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl (N_CH=4, HOLDOFF=16, WDT_CYCLES=200).
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       parity_error = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [3:0] ch_out;
    logic [15:0] cmd_count;
    logic [7:0] err_count;
    logic       wdt_trip;

    int n_checks = 0;
    int n_pass   = 0;

    uart_cmd_ctrl #(
        .N_CH(4), .HOLDOFF(16), .OUT_ACTIVE_LOW(1), .WDT_CYCLES(200)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .parity_error(parity_error), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_start(tx_start), .ch_out(ch_out), .cmd_count(cmd_count),
        .err_count(err_count), .wdt_trip(wdt_trip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic p);
        @(negedge clk);
        rx_data = b; rx_done = 1'b1; parity_error = p;
        @(negedge clk);
        rx_done = 1'b0; parity_error = 1'b0;
    endtask

    // Acts as uart_tx: waits for tx_start, holds busy, optionally fires extra rx bytes meanwhile.
    task automatic get_reply(input string tag, input int n_inject, output logic [7:0] d);
        bit seen = 0;
        d = 8'h00;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            d = tx_data;
            tx_busy = 1'b1;
            @(negedge clk);
            check({tag, "_pulse"}, 32'(tx_start), 32'd0);
            for (int k = 0; k < n_inject; k++) begin
                rx_data = 8'hA3; rx_done = 1'b1;
                @(negedge clk);
                rx_done = 1'b0;
                @(negedge clk);
            end
            repeat (2) @(negedge clk);
            check({tag, "_hold"}, 32'(tx_data), 32'(d));
            tx_busy = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] b, input logic p,
                          input logic [7:0] exp_reply, input logic [3:0] exp_ch);
        logic [7:0] r;
        send_byte(b, p);
        get_reply(tag, 0, r);
        check({tag, "_reply"}, 32'(r), 32'(exp_reply));
        check({tag, "_ch"}, 32'(ch_out), 32'(exp_ch));
    endtask

    initial begin
        logic [7:0] r;
        int starts;
        bit seen;

        repeat (3) @(negedge clk);
        check("rst_ch", 32'(ch_out), 32'hF);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
        check("rst_cmd", 32'(cmd_count), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_wdt", 32'(wdt_trip), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ON ch2 with exact output latency
        send_byte(8'hA2, 1'b0);
        @(negedge clk);
        check("on2_early", 32'(ch_out), 32'hF);
        @(negedge clk);
        check("on2_lat3", 32'(ch_out), 32'hB);
        get_reply("on2", 0, r);
        check("on2_reply", 32'(r), 32'h82);
        check("on2_cmd", 32'(cmd_count), 32'd1);

        do_cmd("tog_hold", 8'hC2, 1'b0, 8'h64, 4'hB);
        check("tog_hold_err", 32'(err_count), 32'd1);
        repeat (20) @(negedge clk);
        do_cmd("tog2", 8'hC2, 1'b0, 8'h82, 4'hF);
        check("tog2_cmd", 32'(cmd_count), 32'd2);

        do_cmd("perr", 8'hA0, 1'b1, 8'h61, 4'hF);
        do_cmd("badop", 8'h20, 1'b0, 8'h62, 4'hF);
        do_cmd("badch", 8'hA7, 1'b0, 8'h63, 4'hF);
        check("err3", 32'(err_count), 32'd4);
        check("err3_cmd", 32'(cmd_count), 32'd2);

        repeat (20) @(negedge clk);
        do_cmd("on1", 8'hA1, 1'b0, 8'h81, 4'hD);
        do_cmd("q1", 8'hE1, 1'b0, 8'h21, 4'hD);
        do_cmd("q0", 8'hE0, 1'b0, 8'h20, 4'hD);
        check("q_cmd", 32'(cmd_count), 32'd5);

        // Overrun while the reply is still being transmitted
        send_byte(8'hE1, 1'b0);
        get_reply("ovr", 1, r);
        check("ovr_reply", 32'(r), 32'h21);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        check("ovr_noreply", 32'(starts), 32'd0);
        check("ovr_err", 32'(err_count), 32'd5);
        check("ovr_cmd", 32'(cmd_count), 32'd6);

        repeat (20) @(negedge clk);
        do_cmd("off_off", 8'h40, 1'b0, 8'h80, 4'hD);
        do_cmd("off_restart", 8'h41, 1'b0, 8'h64, 4'hD);
        check("restart_err", 32'(err_count), 32'd6);
        repeat (20) @(negedge clk);
        do_cmd("tog1", 8'hC1, 1'b0, 8'h81, 4'hF);
        check("tog1_cmd", 32'(cmd_count), 32'd8);

        send_byte(8'hE0, 1'b0);
        get_reply("sat", 260, r);
        check("sat_reply", 32'(r), 32'h20);
        check("sat_err", 32'(err_count), 32'hFF);
        check("sat_cmd", 32'(cmd_count), 32'd9);

        // Asynchronous reset while tx_start is high
        send_byte(8'hE1, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1;
        end
        check("ar_seen", 32'(seen), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_start", 32'(tx_start), 32'd0);
        check("ar_cmd", 32'(cmd_count), 32'd0);
        check("ar_err", 32'(err_count), 32'd0);
        check("ar_txdata", 32'(tx_data), 32'd0);
        check("ar_ch", 32'(ch_out), 32'hF);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef CMD_WDT_EN
        do_cmd("wdt_on", 8'hA0, 1'b0, 8'h80, 4'hE);
        repeat (200) @(negedge clk);
        check("wdt_ch", 32'(ch_out), 32'hF);
        check("wdt_trip", 32'(wdt_trip), 32'd1);
        do_cmd("wdt_on2", 8'hA0, 1'b0, 8'h80, 4'hE);
        check("wdt_clear", 32'(wdt_trip), 32'd0);
`else
        do_cmd("nowdt_on", 8'hA0, 1'b0, 8'h80, 4'hE);
        repeat (200) @(negedge clk);
        check("nowdt_ch", 32'(ch_out), 32'hE);
        check("nowdt_trip", 32'(wdt_trip), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
